cpu_muldiv: RTL and testbench
=============================

# cpu_muldiv

Iterative 32-bit unsigned multiply/divide sequencer attached to the execute stage (stage 2a) alongside the single-cycle ALU. It accepts one operation from stage 2a, stalls that stage while it runs a one-bit-per-cycle shift-add or restoring-divide loop, and returns a registered result with a one-cycle done pulse. A kill from stage 4a aborts any operation in flight.

## Interface
Parameters:
- none; operand width is fixed at 32.

Ports:
- clk  input  1  pipeline clock.
- rst_b  input  1  asynchronous reset, active low.
- md__start_2a  input  1  stage 2a holds a mul/div instruction.
- md__op_2a  input  2  00 MULLO, 01 MULHI, 10 DIV, 11 REM; all unsigned.
- md__left_2a  input  32  multiplicand / dividend.
- md__right_2a  input  32  multiplier / divisor.
- kill_4a  input  1  squash everything younger than stage 4a.
- md__stall_2a  output  1  hold stage 2a; combinational.
- md__done_3a  output  1  result valid this cycle; one-cycle pulse.
- md__out_3a  output  32  result; held until the next completion.
- md__divzero_3a  output  1  divisor was zero; valid with done, then held.

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, counter 0, md__out_3a 0, md__done_3a 0, md__divzero_3a 0.
- IDLE: if md__start_2a && !kill_4a, latch op and operands, clear accumulator, counter <= 0, go to RUN.
- RUN: one step per cycle. Increment the counter. At the step with counter == 31, register the result, go to DONE.
- DONE: md__done_3a = 1. Next edge goes to IDLE unconditionally.
- md__stall_2a = md__start_2a && !kill_4a && state != DONE.
- MUL: 64-bit shift-add product. MULLO returns bits [31:0]; MULHI returns bits [63:32].
- DIV/REM: restoring division on a 33-bit partial remainder. DIV returns the quotient; REM returns the remainder.
- Divisor 0: the full latency is still taken. DIV returns 0xFFFFFFFF; REM returns the dividend; md__divzero_3a = 1.
- For all other completions, md__divzero_3a = 0.
- Kill: kill_4a in any state returns the block to IDLE on the next edge.
  - No done pulse is produced.
  - md__out_3a and md__divzero_3a keep their old values.
  - md__stall_2a is low whenever kill_4a is high.
- Start and kill in the same IDLE cycle: the start is ignored.
- Operands are latched, so stage-2a input changes during RUN have no effect.

## Timing
- Cycle c0: the start is seen in IDLE; stall is high.
- Cycles c1..c32: RUN; stall stays high.
- Cycle c33: DONE. Stall is low, md__done_3a = 1 and md__out_3a is valid, and the instruction advances at the end of c33.
- The total latency is therefore 34 cycles in stage 2a and 33 stalled cycles.
- Back-to-back operations: a second mul/div reaches stage 2a in c34. Its start is seen in IDLE at c34.
- An asynchronous reset mid-operation forces every reset value immediately. No done pulse follows.

## Configuration
- MULDIV_DIV_EN defined: DIV and REM behave as described above.
- MULDIV_DIV_EN undefined: the divider datapath is omitted.
  - A DIV or REM start goes IDLE -> DONE directly, a 2-cycle latency with stall high for 1 cycle.
  - md__out_3a = 0 and md__divzero_3a = 0.
  - MUL timing is unchanged.

## Test plan
- MULLO and then MULHI of 0xFFFFFFFF × 0xFFFFFFFF -> out 0x00000001, then 0xFFFFFFFE. Done occurs at c33 each time, with stall high for exactly 33 cycles.
- DIV 100/7 -> 0x0000000E; REM 100/7 -> 0x00000002; divzero 0 in both cases.
- DIV 5/0 -> 0xFFFFFFFF with divzero 1; REM 5/0 -> 0x00000005 with divzero 1.
- Start MUL 3×4, then assert kill_4a at RUN cycle 10.
  - Required: no done pulse, out keeps its previous value, and the state is IDLE next cycle.
  - A following MULLO 6×7 -> 0x0000002A at full latency.
- Deassert rst_b at RUN cycle 20 -> all outputs are 0 immediately, and no done pulse follows release.
- Run with MULDIV_DIV_EN undefined: DIV 100/7 -> done at c1 with out 0, and MULLO 2×3 -> 0x00000006 at c33.

Source files
------------

// File: rtl/cpu_muldiv.sv
// cpu_muldiv: iterative 32-bit unsigned multiply/divide sequencer beside the
// stage-2a ALU. Accepts one op from stage 2a, stalls 2a while a
// one-bit-per-cycle shift-add multiply or restoring divide runs, then presents
// a registered result with a one-cycle done pulse. kill_4a aborts any op.
//
// Ports:
//   clk            pipeline clock
//   rst_b          asynchronous reset, active low
//   md__start_2a   stage 2a holds a mul/div instruction
//   md__op_2a      00 MULLO, 01 MULHI, 10 DIV, 11 REM (all unsigned)
//   md__left_2a    multiplicand / dividend
//   md__right_2a   multiplier / divisor
//   kill_4a        squash everything younger than stage 4a
//   md__stall_2a   hold stage 2a (combinational)
//   md__done_3a    result valid this cycle (one-cycle pulse)
//   md__out_3a     result, held until the next completion
//   md__divzero_3a divisor was zero; valid with done, then held
//
// Configuration macro: MULDIV_DIV_EN. When undefined the divider datapath is
// omitted; DIV/REM complete in two cycles with out = 0 and divzero = 0.
module cpu_muldiv (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        md__start_2a,
  input  logic [1:0]  md__op_2a,
  input  logic [31:0] md__left_2a,
  input  logic [31:0] md__right_2a,
  input  logic        kill_4a,
  output logic        md__stall_2a,
  output logic        md__done_3a,
  output logic [31:0] md__out_3a,
  output logic        md__divzero_3a
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_MULLO = 2'd0;
  localparam logic [1:0] OP_MULHI = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_REM   = 2'd3;

  state_t      state;
  logic [4:0]  count;
  logic        accept;

  logic [1:0]  op_p1;
  logic [31:0] mcand_p1;
  logic [63:0] prod_p1;
  logic [32:0] sum_p1;
  logic [63:0] prod_nxt;

  logic [31:0] result;
  logic        result_dz;

  assign accept       = (state == IDLE) && md__start_2a && !kill_4a;
  assign md__stall_2a = md__start_2a && !kill_4a && (state != DONE);

  // ---- stage p1: iteration datapath ----
  // Product register starts as {0, multiplier}; each step adds the multiplicand
  // into the upper half when the current LSB is set, then shifts right with
  // the carry so the 64-bit product emerges after 32 steps.
  always_comb begin
    sum_p1   = {1'b0, prod_p1[63:32]} + (prod_p1[0] ? {1'b0, mcand_p1} : 33'd0);
    prod_nxt = {sum_p1, prod_p1[31:1]};
  end

`ifdef MULDIV_DIV_EN
  logic [31:0] divisor_p1;
  logic [31:0] quo_p1;
  logic [31:0] rem_p1;
  logic [32:0] shifted;
  logic [31:0] trial;
  logic        fits;
  logic [31:0] quo_nxt;
  logic [31:0] rem_nxt;
  logic        div_zero;

  // Restoring divide: the 33-bit partial remainder is the stored remainder
  // shifted left with the next dividend bit. When it fits, the difference is
  // below the divisor so the low 32 bits of a modulo subtract are exact.
  // A zero divisor makes every step "fit", which naturally yields an all-ones
  // quotient and leaves the dividend as the remainder.
  always_comb begin
    shifted  = {rem_p1, quo_p1[31]};
    fits     = (shifted >= {1'b0, divisor_p1});
    trial    = shifted[31:0] - divisor_p1;
    rem_nxt  = fits ? trial : shifted[31:0];
    quo_nxt  = {quo_p1[30:0], fits};
    div_zero = (divisor_p1 == 32'd0);
  end
`endif

  always_comb begin
    result    = 32'd0;
    result_dz = 1'b0;
    case (op_p1)
      OP_MULLO: result = prod_nxt[31:0];
      OP_MULHI: result = prod_nxt[63:32];
`ifdef MULDIV_DIV_EN
      OP_DIV: begin
        result    = quo_nxt;
        result_dz = div_zero;
      end
      OP_REM: begin
        result    = rem_nxt;
        result_dz = div_zero;
      end
`endif
      default: begin
        result    = 32'd0;
        result_dz = 1'b0;
      end
    endcase
  end

  // Operand and iteration registers carry no reset; they are always loaded
  // on accept before being consumed.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p1    <= md__op_2a;
      mcand_p1 <= md__left_2a;
      prod_p1  <= {32'd0, md__right_2a};
`ifdef MULDIV_DIV_EN
      divisor_p1 <= md__right_2a;
      quo_p1     <= md__left_2a;
      rem_p1     <= 32'd0;
`endif
    end else if (state == RUN) begin
      prod_p1 <= prod_nxt;
`ifdef MULDIV_DIV_EN
      quo_p1  <= quo_nxt;
      rem_p1  <= rem_nxt;
`endif
    end
  end

  // ---- stage 3a: sequencer and registered outputs ----
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state          <= IDLE;
      count          <= 5'd0;
      md__done_3a    <= 1'b0;
      md__out_3a     <= 32'd0;
      md__divzero_3a <= 1'b0;
    end else begin
      md__done_3a <= 1'b0;
      if (kill_4a) begin
        state <= IDLE;
        count <= 5'd0;
      end else begin
        case (state)
          IDLE: begin
            if (md__start_2a) begin
              count <= 5'd0;
`ifdef MULDIV_DIV_EN
              state <= RUN;
`else
              if (md__op_2a[1]) begin
                state          <= DONE;
                md__done_3a    <= 1'b1;
                md__out_3a     <= 32'd0;
                md__divzero_3a <= 1'b0;
              end else begin
                state <= RUN;
              end
`endif
            end
          end
          RUN: begin
            count <= count + 5'd1;
            if (count == 5'd31) begin
              state          <= DONE;
              md__done_3a    <= 1'b1;
              md__out_3a     <= result;
              md__divzero_3a <= result_dz;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_muldiv.sv
// Testbench for cpu_muldiv: table of directed operations with hand-computed
// results and latencies, plus sequences for kill, start+kill and mid-op reset.
// Divider vectors follow the MULDIV_DIV_EN setting of the build.
module tb_cpu_muldiv;

  logic        clk;
  logic        rst_b;
  logic        md__start_2a;
  logic [1:0]  md__op_2a;
  logic [31:0] md__left_2a;
  logic [31:0] md__right_2a;
  logic        kill_4a;
  logic        md__stall_2a;
  logic        md__done_3a;
  logic [31:0] md__out_3a;
  logic        md__divzero_3a;

  int errors = 0;
  int checks = 0;

  cpu_muldiv dut (
    .clk            (clk),
    .rst_b          (rst_b),
    .md__start_2a   (md__start_2a),
    .md__op_2a      (md__op_2a),
    .md__left_2a    (md__left_2a),
    .md__right_2a   (md__right_2a),
    .kill_4a        (kill_4a),
    .md__stall_2a   (md__stall_2a),
    .md__done_3a    (md__done_3a),
    .md__out_3a     (md__out_3a),
    .md__divzero_3a (md__divzero_3a)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] eo;
    logic        edz;
    int          lat;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, exp);
    end
  endtask

  // Issue one op at the next negedge (cycle c0) and follow it to done.
  task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] l,
                       input logic [31:0] r, input logic [31:0] eo, input logic edz,
                       input int lat);
    int cyc;
    int stalls;
    int done_cyc;
    logic [31:0] got_out;
    logic        got_dz;
    @(negedge clk);
    md__start_2a = 1'b1;
    md__op_2a    = op;
    md__left_2a  = l;
    md__right_2a = r;
    cyc = 0; stalls = 0; done_cyc = -1; got_out = 32'd0; got_dz = 1'b0;
    #1;
    chk({nm, "_done_c0"}, {31'd0, md__done_3a}, 32'd0);
    while (cyc < 60) begin
      if (md__stall_2a) stalls++;
      if (md__done_3a && cyc > 0) begin
        done_cyc = cyc;
        got_out  = md__out_3a;
        got_dz   = md__divzero_3a;
        break;
      end
      @(negedge clk);
      cyc++;
      // Operands may wander while the op is in flight.
      md__left_2a  = $urandom;
      md__right_2a = $urandom;
      #1;
    end
    md__start_2a = 1'b0;
    chk({nm, "_latency"}, done_cyc, lat);
    chk({nm, "_stalls"}, stalls, lat);
    chk({nm, "_out"}, got_out, eo);
    chk({nm, "_divzero"}, {31'd0, got_dz}, {31'd0, edz});
  endtask

  // Run n cycles with idle inputs and count done pulses.
  task automatic quiet(input string nm, input int n);
    int dones;
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      if (md__done_3a) dones++;
    end
    chk({nm, "_no_done"}, dones, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_b = 1'b0; md__start_2a = 1'b0; md__op_2a = 2'd0;
    md__left_2a = 32'd0; md__right_2a = 32'd0; kill_4a = 1'b0;

    // op, left, right, expected out, expected divzero, latency
    tbl.push_back('{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33});
    tbl.push_back('{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33});
    tbl.push_back('{2'd0, 32'h12345678, 32'h00000010, 32'h23456780, 1'b0, 33});
    tbl.push_back('{2'd1, 32'h12345678, 32'h00000010, 32'h00000001, 1'b0, 33});
    tbl.push_back('{2'd1, 32'h80000000, 32'h00000004, 32'h00000002, 1'b0, 33});
    tbl.push_back('{2'd0, 32'h00000000, 32'h00001234, 32'h00000000, 1'b0, 33});
`ifdef MULDIV_DIV_EN
    tbl.push_back('{2'd2, 32'd100, 32'd7, 32'h0000000E, 1'b0, 33});
    tbl.push_back('{2'd3, 32'd100, 32'd7, 32'h00000002, 1'b0, 33});
    tbl.push_back('{2'd2, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 33});
    tbl.push_back('{2'd3, 32'd5, 32'd0, 32'h00000005, 1'b1, 33});
    tbl.push_back('{2'd0, 32'd2, 32'd3, 32'h00000006, 1'b0, 33});
    tbl.push_back('{2'd2, 32'h80000000, 32'd3, 32'h2AAAAAAA, 1'b0, 33});
    tbl.push_back('{2'd3, 32'h80000000, 32'd3, 32'h00000002, 1'b0, 33});
    tbl.push_back('{2'd2, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 1'b0, 33});
    tbl.push_back('{2'd3, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0, 33});
    tbl.push_back('{2'd3, 32'd7, 32'd100, 32'h00000007, 1'b0, 33});
`else
    tbl.push_back('{2'd2, 32'd100, 32'd7, 32'h00000000, 1'b0, 1});
    tbl.push_back('{2'd3, 32'd100, 32'd7, 32'h00000000, 1'b0, 1});
    tbl.push_back('{2'd2, 32'd5, 32'd0, 32'h00000000, 1'b0, 1});
    tbl.push_back('{2'd1, 32'hDEADBEEF, 32'h00000002, 32'h00000001, 1'b0, 33});
    tbl.push_back('{2'd3, 32'd5, 32'd0, 32'h00000000, 1'b0, 1});
`endif
    tbl.push_back('{2'd0, 32'd2, 32'd3, 32'h00000006, 1'b0, 33});

    repeat (2) @(negedge clk);
    #1;
    chk("reset_out", md__out_3a, 32'd0);
    chk("reset_done", {31'd0, md__done_3a}, 32'd0);
    chk("reset_divzero", {31'd0, md__divzero_3a}, 32'd0);
    chk("reset_stall", {31'd0, md__stall_2a}, 32'd0);
    rst_b = 1'b1;

    // Back-to-back table: each op starts the cycle after the previous done.
    foreach (tbl[i])
      do_op($sformatf("v%0d", i), tbl[i].op, tbl[i].l, tbl[i].r,
            tbl[i].eo, tbl[i].edz, tbl[i].lat);

    // Kill at RUN cycle 10: no done, out held, back in IDLE.
    @(negedge clk);
    md__start_2a = 1'b1; md__op_2a = 2'd0; md__left_2a = 32'd3; md__right_2a = 32'd4;
    repeat (10) @(negedge clk);
    kill_4a = 1'b1;
    #1;
    chk("kill_stall", {31'd0, md__stall_2a}, 32'd0);
    @(negedge clk);
    kill_4a = 1'b0; md__start_2a = 1'b0;
    quiet("kill", 40);
    chk("kill_out_held", md__out_3a, 32'h00000006);
    chk("kill_dz_held", {31'd0, md__divzero_3a}, 32'd0);
    do_op("after_kill", 2'd0, 32'd6, 32'd7, 32'h0000002A, 1'b0, 33);

    // Start and kill together in IDLE: start ignored.
    @(negedge clk);
    md__start_2a = 1'b1; md__op_2a = 2'd1; md__left_2a = 32'hFFFFFFFF; md__right_2a = 32'hFFFFFFFF;
    kill_4a = 1'b1;
    #1;
    chk("startkill_stall", {31'd0, md__stall_2a}, 32'd0);
    @(negedge clk);
    md__start_2a = 1'b0; kill_4a = 1'b0;
    quiet("startkill", 40);
    chk("startkill_out_held", md__out_3a, 32'h0000002A);

    // Asynchronous reset at RUN cycle 20.
    @(negedge clk);
    md__start_2a = 1'b1; md__op_2a = 2'd0; md__left_2a = 32'hFFFFFFFF; md__right_2a = 32'hFFFFFFFF;
    repeat (20) @(negedge clk);
    rst_b = 1'b0; md__start_2a = 1'b0;
    #1;
    chk("rst_mid_out", md__out_3a, 32'd0);
    chk("rst_mid_done", {31'd0, md__done_3a}, 32'd0);
    chk("rst_mid_divzero", {31'd0, md__divzero_3a}, 32'd0);
    chk("rst_mid_stall", {31'd0, md__stall_2a}, 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    quiet("rst_release", 40);
    chk("rst_release_out", md__out_3a, 32'd0);
    do_op("after_rst", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
